// File: rtl/comp_arch_pkg.sv
// rtl/comp_arch_pkg.sv - shared opcode, error-code and width definitions
package comp_arch_pkg;

    localparam int DW = 32;
    localparam int RW = 5;

    typedef enum logic [5:0] {
        OP_ADD  = 6'b000000,
        OP_SUB  = 6'b000001,
        OP_AND  = 6'b000010,
        OP_OR   = 6'b000011,
        OP_XOR  = 6'b000100,
        OP_NOR  = 6'b000101,
        OP_SLL  = 6'b000110,
        OP_SRL  = 6'b000111,
        OP_SRA  = 6'b001000,
        OP_SLT  = 6'b001001,
        OP_SLTU = 6'b001010,
        OP_MUL  = 6'b001011,
        OP_LDW  = 6'b001100,
        OP_STW  = 6'b001101
    } opcode_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } err_code_e;

    // ALU ops occupy the contiguous range up to OP_MUL.
    function automatic logic is_alu_op(input logic [5:0] op);
        return op <= OP_MUL;
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LDW) || (op == OP_STW);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - saturating wait counter flagging a stalled memory request
module mem_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    // Count unacknowledged request cycles; hold at LAST so expiry stays asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory-access / write-back stage with req/ack data port
module mem_wb_stage #(
    parameter int DW      = comp_arch_pkg::DW,
    parameter int RW      = comp_arch_pkg::RW,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [5:0]    in_op,
    input  logic [DW-1:0] in_result,
    input  logic [DW-1:0] in_addr,
    input  logic [DW-1:0] in_sdata,
    input  logic [RW-1:0] in_rd_idx,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          wb_en,
    output logic [RW-1:0] wb_idx,
    output logic [DW-1:0] wb_data,
    output logic          err,
    output logic [1:0]    err_code
);

    import comp_arch_pkg::*;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } mem_wb_state_e;

    mem_wb_state_e state_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [DW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [RW-1:0] ld_rd_q;
    logic          wb_en_q;
    logic [RW-1:0] wb_idx_q;
    logic [DW-1:0] wb_data_q;
    logic          err_q;
    err_code_e     err_code_q;

    logic accept;
    logic aligned;
    logic ctr_expire;

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_valid && in_ready;
    assign aligned  = (in_addr[1:0] == 2'b00);

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_q == S_IDLE),
        .en_i     ((state_q == S_REQ) && !mem_ack),
        .expire_o (ctr_expire)
    );

    // Stage FSM: dispatch accepted ops, run the memory handshake, register all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ld_rd_q     <= '0;
            wb_en_q     <= 1'b0;
            wb_idx_q    <= '0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            wb_en_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (is_alu_op(in_op)) begin
                            // r0 is hard-wired; suppress the strobe but keep the data path simple.
                            wb_en_q   <= (in_rd_idx != '0);
                            wb_idx_q  <= in_rd_idx;
                            wb_data_q <= in_result;
                        end else if (is_mem_op(in_op)) begin
                            if (aligned) begin
                                state_q     <= S_REQ;
                                mem_req_q   <= 1'b1;
                                mem_we_q    <= (in_op == OP_STW);
                                mem_addr_q  <= in_addr;
                                mem_wdata_q <= in_sdata;
                                ld_rd_q     <= in_rd_idx;
                            end else begin
                                err_q      <= 1'b1;
                                err_code_q <= ERR_MISALIGN;
                            end
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_ILLEGAL;
                        end
                    end
                end
                S_REQ: begin
                    // An ack in the expiry cycle still completes the access.
                    if (mem_ack) begin
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) begin
                            wb_en_q   <= (ld_rd_q != '0);
                            wb_idx_q  <= ld_rd_q;
                            wb_data_q <= mem_rdata;
                        end
                    end else if (ctr_expire) begin
                        state_q    <= S_IDLE;
                        mem_req_q  <= 1'b0;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_en     = wb_en_q;
    assign wb_idx    = wb_idx_q;
    assign wb_data   = wb_data_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_op = '0;
    logic [31:0] in_result = '0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_sdata = '0;
    logic [4:0]  in_rd_idx = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_en;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data;
    logic        err;
    logic [1:0]  err_code;

    int tests = 0;
    int fails = 0;
    bit cmp_on = 0;

    mem_wb_stage #(.DW(32), .RW(5), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_result(in_result), .in_addr(in_addr), .in_sdata(in_sdata), .in_rd_idx(in_rd_idx),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding memory access, cycles waited, outputs expected next cycle.
    bit          m_busy = 0;
    bit          m_load = 0;
    int          m_waited = 0;
    logic [4:0]  m_rd = '0;
    bit          e_req = 0, e_we = 0, e_wb = 0, e_err = 0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_wb_data = '0;
    logic [4:0]  e_wb_idx = '0;
    logic [1:0]  e_code = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_waited = 0; e_req = 0; e_we = 0; e_wb = 0; e_err = 0;
            e_addr = '0; e_wdata = '0; e_wb_data = '0; e_wb_idx = '0; e_code = '0;
        end else begin
            e_wb = 0;
            e_err = 0;
            if (!m_busy) begin
                if (in_valid) begin
                    if (in_op < 12) begin
                        e_wb = (in_rd_idx != 0);
                        e_wb_idx = in_rd_idx;
                        e_wb_data = in_result;
                    end else if (in_op == 12 || in_op == 13) begin
                        if (in_addr % 4 != 0) begin
                            e_err = 1; e_code = 2'd1;
                        end else begin
                            m_busy = 1; m_waited = 0; m_load = (in_op == 12); m_rd = in_rd_idx;
                            e_req = 1; e_we = (in_op == 13); e_addr = in_addr; e_wdata = in_sdata;
                        end
                    end else begin
                        e_err = 1; e_code = 2'd3;
                    end
                end
            end else begin
                m_waited++;
                if (mem_ack) begin
                    m_busy = 0; e_req = 0;
                    if (m_load) begin
                        e_wb = (m_rd != 0); e_wb_idx = m_rd; e_wb_data = mem_rdata;
                    end
                end else if (m_waited == TO) begin
                    m_busy = 0; e_req = 0; e_err = 1; e_code = 2'd2;
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("m_in_ready", 32'(in_ready), 32'(!m_busy));
            check("m_mem_req", 32'(mem_req), 32'(e_req));
            if (e_req) begin
                check("m_mem_we", 32'(mem_we), 32'(e_we));
                check("m_mem_addr", mem_addr, e_addr);
                check("m_mem_wdata", mem_wdata, e_wdata);
            end
            check("m_wb_en", 32'(wb_en), 32'(e_wb));
            if (e_wb) begin
                check("m_wb_idx", 32'(wb_idx), 32'(e_wb_idx));
                check("m_wb_data", wb_data, e_wb_data);
            end
            check("m_err", 32'(err), 32'(e_err));
            check("m_err_code", 32'(err_code), 32'(e_code));
        end
    end

    task automatic issue(input logic [5:0] op, input logic [31:0] res, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [4:0] rd);
        in_valid = 1; in_op = op; in_result = res; in_addr = addr; in_sdata = sd; in_rd_idx = rd;
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    int req_cycles;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_wb_en", 32'(wb_en), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        rst_n = 1; cmp_on = 1;
        @(negedge clk);

        // ALU pass-through
        issue(6'b000000, 32'h5, 32'h0, 32'h0, 5'd3);
        @(negedge clk);
        check("alu_wb_en", 32'(wb_en), 32'd1);
        check("alu_wb_idx", 32'(wb_idx), 32'd3);
        check("alu_wb_data", wb_data, 32'h5);

        // back-to-back ALU
        issue(6'b000001, 32'hA, 32'h0, 32'h0, 5'd4);
        issue(6'b001011, 32'hB, 32'h0, 32'h0, 5'd5);
        @(negedge clk);
        check("b2b_wb_idx", 32'(wb_idx), 32'd5);
        check("b2b_wb_data", wb_data, 32'hB);

        // LDW with ack on the third request cycle
        issue(6'b001100, 32'h0, 32'h100, 32'h0, 5'd7);
        @(negedge clk);
        check("ldw_req", 32'(mem_req), 32'd1);
        check("ldw_ready", 32'(in_ready), 32'd0);
        check("ldw_addr", mem_addr, 32'h100);
        check("ldw_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        @(posedge clk); #1 mem_ack = 0; mem_rdata = '0;
        @(negedge clk);
        check("ldw_wb_en", 32'(wb_en), 32'd1);
        check("ldw_wb_idx", 32'(wb_idx), 32'd7);
        check("ldw_wb_data", wb_data, 32'hDEADBEEF);
        check("ldw_ready_after", 32'(in_ready), 32'd1);
        check("ldw_req_after", 32'(mem_req), 32'd0);
        // accept during the outgoing write-back pulse
        issue(6'b000010, 32'h77, 32'h0, 32'h0, 5'd9);
        @(negedge clk);
        check("overlap_wb_data", wb_data, 32'h77);

        // STW acked on first request cycle
        issue(6'b001101, 32'h0, 32'h204, 32'h12345678, 5'd2);
        mem_ack = 1;
        @(negedge clk);
        check("stw_we", 32'(mem_we), 32'd1);
        check("stw_addr", mem_addr, 32'h204);
        check("stw_wdata", mem_wdata, 32'h12345678);
        @(posedge clk); #1 mem_ack = 0;
        @(negedge clk);
        check("stw_no_wb", 32'(wb_en), 32'd0);
        check("stw_req_drop", 32'(mem_req), 32'd0);

        // misaligned LDW
        issue(6'b001100, 32'h0, 32'h102, 32'h0, 5'd6);
        @(negedge clk);
        check("mis_err", 32'(err), 32'd1);
        check("mis_code", 32'(err_code), 32'd1);
        check("mis_req", 32'(mem_req), 32'd0);

        // illegal opcode
        issue(6'b111111, 32'h0, 32'h0, 32'h0, 5'd1);
        @(negedge clk);
        check("ill_err", 32'(err), 32'd1);
        check("ill_code", 32'(err_code), 32'd3);
        check("ill_no_wb", 32'(wb_en), 32'd0);

        // r0 destination
        issue(6'b000000, 32'h99, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        check("r0_no_wb", 32'(wb_en), 32'd0);

        // ack while idle is ignored
        mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ack = 0;
        @(negedge clk);
        check("idle_ack_wb", 32'(wb_en), 32'd0);

        // timeout
        issue(6'b001100, 32'h0, 32'h300, 32'h0, 5'd8);
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req) req_cycles++;
            else break;
        end
        check("to_req_cycles", 32'(req_cycles), 32'd16);
        check("to_err", 32'(err), 32'd1);
        check("to_code", 32'(err_code), 32'd2);
        check("to_no_wb", 32'(wb_en), 32'd0);
        mem_ack = 1; mem_rdata = 32'h1234;
        @(negedge clk);
        mem_ack = 0;
        @(negedge clk);
        check("late_ack_wb", 32'(wb_en), 32'd0);

        // async reset during a request
        issue(6'b001100, 32'h0, 32'h400, 32'h0, 5'd10);
        @(negedge clk);
        check("ar_req_before", 32'(mem_req), 32'd1);
        #2 rst_n = 0;
        #1;
        check("ar_req_drop", 32'(mem_req), 32'd0);
        check("ar_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("ar_ready_after", 32'(in_ready), 32'd1);
        check("ar_no_wb", 32'(wb_en), 32'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
